bg_rom_arbiter: RTL and testbench
=================================

Name: bg_rom_arbiter

Overview:
Shares the single read port of the 640x480 background image BRAM (19-bit address, 16-bit RGB565 data, registered read) between two requesters. The pixel compositor is hard real-time and owns the port every cycle of active video. The collision/physics logic issues sparse lookups over a req/gnt/valid handshake, normally serviced during blanking. The block sits between the compositor/game logic and the BRAM instance and routes each returning word to its owner by tag.

Parameters:
AW, 19, BRAM address width
DW, 16, pixel data width
RD_LAT, 1, BRAM read latency in clocks (1..3)
STARVE_LIMIT, 800, max cycles a collision request may wait (guard feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
video_active  in  1  compositor needs the port this cycle
pix_addr  in  AW  compositor read address, sampled every cycle
pix_data  out  DW  pixel word returned to compositor
pix_valid  out  1  pix_data corresponds to an active-video request
col_req  in  1  collision lookup request, level
col_addr  in  AW  collision address, stable while col_req high
col_gnt  out  1  one-cycle pulse: col_addr has been issued
col_data  out  DW  collision word, held until next col_valid
col_valid  out  1  one-cycle pulse: col_data updated
bram_addr  out  AW  registered address to BRAM
bram_dout  in  DW  BRAM read data

Behaviour:
- Reset: bram_addr=0, pix_data=0, pix_valid=0, col_gnt=0, col_data=0, col_valid=0, FSM=IDLE, tag pipe cleared to OWN_NONE. Reset mid-transaction drops the read; no col_valid is produced for it.
- Slot decision at each rising edge E0:
  - video_active=1: bram_addr<=pix_addr, tag OWN_PIX.
  - else, if FSM=IDLE and col_req=1: bram_addr<=col_addr, tag OWN_COL, col_gnt=1 for one cycle.
  - else: bram_addr<=pix_addr, tag OWN_NONE.
- Tag pipe delays the tag RD_LAT+1 stages. At edge E(RD_LAT+1), bram_dout is registered into pix_data or col_data per tag:
  - OWN_PIX: pix_data updated, pix_valid=1.
  - OWN_COL: col_data updated, col_valid pulses 1.
  - OWN_NONE: pix_valid=0, pix_data unchanged.
- Latency: RD_LAT+1 clocks from sampling edge to output (2 at default). The pixel stream is bit-exact and in order, with no bubbles while video_active is held.
- FSM (one outstanding collision read):
  - IDLE -> WAIT on grant.
  - WAIT counts RD_LAT+1 cycles -> DONE on col_valid.
  - DONE -> IDLE.
  - col_req still high in DONE is a new request. Minimum spacing between grants is RD_LAT+3 cycles.
- Requester protocol: col_req/col_addr held until col_gnt seen. col_req dropped before grant is a legal cancel with no side effects.
- Simultaneous video_active rise and col_req: pixel wins; collision waits.
- video_active rising while a collision read is in flight: no conflict, since the read already holds its tag and pixel slots proceed.
- Address arithmetic is the caller's (y*640+x); no range check; values above 307199 are passed through unchanged.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A wait counter increments each cycle col_req=1 and FSM=IDLE without a grant, and clears on grant or when col_req falls.
  - On reaching STARVE_LIMIT, the next slot goes to collision even if video_active=1.
  - The stolen pixel return keeps pix_valid=1 and repeats the previous pix_data (one duplicated pixel).
- Undefined: collision is serviced only when video_active=0; a request may wait unboundedly. Counter logic is absent.

Decomposition:
- Package bg_arb_pkg:
  - AW/DW defaults, BG_WIDTH=640, BG_HEIGHT=480.
  - owner_t enum {OWN_NONE, OWN_PIX, OWN_COL}.
  - arb_state_t {IDLE, WAIT, DONE}.
- Sub-module bg_rd_tag_pipe: RD_LAT+1-deep shift register of owner_t with async reset. Unit-testable alone.

Test Plan:
- Reset: rst=1 mid-run -> all outputs 0 immediately; after release with video_active=0 and col_req=0, bram_addr tracks pix_addr and pix_valid stays 0.
- Pixel stream: video_active=1 for 640 cycles, pix_addr=0..639, BRAM model returns addr[15:0] -> pix_data=0..639 starting 2 cycles later, pix_valid high for exactly 640 cycles.
- Blanking lookup: video_active=0, col_req=1, col_addr=19'd1283 -> col_gnt at next edge; col_valid 2 cycles after col_gnt with col_data=16'd1283.
- Contention: col_req rises while video_active=1 for 100 cycles (guard undefined) -> no col_gnt in those cycles; grant on first cycle video_active=0; pixel data uncorrupted.
- Back-to-back: col_req held high with address changing after each gnt -> grants spaced exactly 4 cycles apart (RD_LAT=1); each col_data matches its address.
- Guard (ARB_STARVE_GUARD_EN, STARVE_LIMIT=10): video_active held 1, col_req=1 -> col_gnt on the 11th cycle of waiting; that pixel return duplicates the prior pix_data; col_data correct.

Source files
------------

// File: rtl/bg_arb_pkg.sv
// Shared types and constants for the background-image BRAM read-port arbiter.
package bg_arb_pkg;

    localparam int BG_AW     = 19;
    localparam int BG_DW     = 16;
    localparam int BG_WIDTH  = 640;
    localparam int BG_HEIGHT = 480;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIX  = 2'd1,
        OWN_COL  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Linear address of pixel (x, y); callers own the range, the arbiter never checks it.
    function automatic logic [BG_AW-1:0] bg_addr(input int unsigned x, input int unsigned y);
        return BG_AW'(y * BG_WIDTH + x);
    endfunction

endpackage

// File: rtl/bg_rd_tag_pipe.sv
// Ownership tag delay line: follows each BRAM read from issue to the edge its data is captured.
module bg_rd_tag_pipe
    import bg_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage [DEPTH];

    // NOTE: this array is a handful of control flops, not a memory, so it is reset; a read in flight at reset must never surface later as a stale owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/bg_rom_arbiter.sv
// Shares the background BRAM read port between the pixel compositor and collision lookups.
// Optional starvation guard for collision requests: define ARB_STARVE_GUARD_EN.
module bg_rom_arbiter
    import bg_arb_pkg::*;
#(
    parameter int AW           = BG_AW,
    parameter int DW           = BG_DW,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          video_active,
    input  logic [AW-1:0] pix_addr,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          col_req,
    input  logic [AW-1:0] col_addr,
    output logic          col_gnt,
    output logic [DW-1:0] col_data,
    output logic          col_valid,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("bg_rom_arbiter: RD_LAT must be 1..3");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("bg_rom_arbiter: STARVE_LIMIT must be positive");
    end

    localparam int WCW = $clog2(RD_LAT + 1) + 1;

    arb_state_t    state, state_next;
    logic [WCW-1:0] wait_cnt;
    logic          col_issue;
    logic          starve;
    owner_t        slot_tag;
    logic [AW-1:0] slot_addr;
    owner_t        tail_tag;
    logic          tail_steal;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_cnt;
    logic [RD_LAT:0] steal_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!col_req || col_issue) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve = (starve_cnt >= SCW'(STARVE_LIMIT));

    // A collision slot taken during active video still owes the compositor a pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) steal_pipe <= '0;
        else     steal_pipe <= {steal_pipe[RD_LAT-1:0], col_issue & video_active};
    end

    assign tail_steal = steal_pipe[RD_LAT];
`else
    assign starve     = 1'b0;
    assign tail_steal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (col_issue) state_next = WAIT;
            WAIT:    if (wait_cnt == WCW'(RD_LAT)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        col_issue = (state == IDLE) && col_req && (!video_active || starve);
        slot_tag  = OWN_NONE;
        slot_addr = pix_addr;
        if (col_issue) begin
            slot_tag  = OWN_COL;
            slot_addr = col_addr;
        end else if (video_active) begin
            slot_tag  = OWN_PIX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                wait_cnt <= '0;
        else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
        else                    wait_cnt <= '0;
    end

    bg_rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (slot_tag),
        .tag_out (tail_tag)
    );

    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr <= '0;
            col_gnt   <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            col_data  <= '0;
            col_valid <= 1'b0;
        end else begin
            bram_addr <= slot_addr;
            col_gnt   <= col_issue;
            case (tail_tag)
                OWN_PIX: begin
                    pix_data  <= bram_dout;
                    pix_valid <= 1'b1;
                    col_valid <= 1'b0;
                end
                OWN_COL: begin
                    col_data  <= bram_dout;
                    col_valid <= 1'b1;
                    pix_valid <= tail_steal;
                end
                default: begin
                    pix_valid <= 1'b0;
                    col_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Scoreboard bench for bg_rom_arbiter; covers the guarded build when ARB_STARVE_GUARD_EN is defined.
module tb_bg_rom_arbiter;
    import bg_arb_pkg::*;

    localparam int AW           = 19;
    localparam int DW           = 16;
    localparam int RD_LAT       = 1;
    localparam int STARVE_LIMIT = 10;
    localparam int LAT          = RD_LAT + 1;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          video_active;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          col_req;
    logic [AW-1:0] col_addr;
    logic          col_gnt;
    logic [DW-1:0] col_data;
    logic          col_valid;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;

    always #5 clk = ~clk;

    bg_rom_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .video_active (video_active),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .col_req      (col_req),
        .col_addr     (col_addr),
        .col_gnt      (col_gnt),
        .col_data     (col_data),
        .col_valid    (col_valid),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout)
    );

    // BRAM contents: low address bits with the top bits folded in so high addresses stay distinguishable
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[18:16], 13'd0};
    endfunction

    logic [DW-1:0] rom_pipe [RD_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(bram_addr);
        for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bram_dout = rom_pipe[RD_LAT-1];

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t gnt_q[$];
    exp_t pix_q[$];
    exp_t col_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the read port is a slot per edge; pixel wins, one collision read at a time
    int            grant_ok_at;
    int            wait_cycles;
    logic [DW-1:0] last_pix;
    logic [AW-1:0] pix_ptr;

    task automatic model_edge(input logic va, input logic [AW-1:0] pa,
                              input logic cr, input logic [AW-1:0] ca);
        int   e;
        logic idle, starved, granted;
        e       = cyc + 1;
        idle    = (e >= grant_ok_at);
        starved = GUARD && (wait_cycles >= STARVE_LIMIT);
        granted = cr && idle && (!va || starved);
        addr_q.push_back('{e, 32'(granted ? ca : pa)});
        if (granted) begin
            gnt_q.push_back('{e, 32'd1});
            col_q.push_back('{e + LAT, 32'(rom_word(ca))});
            grant_ok_at = e + RD_LAT + 3;
            if (va) pix_q.push_back('{e + LAT, 32'(last_pix)});
        end else if (va) begin
            pix_q.push_back('{e + LAT, 32'(rom_word(pa))});
            last_pix = rom_word(pa);
        end
        if (!cr || granted) wait_cycles = 0;
        else if (idle)      wait_cycles++;
    endtask

    task automatic step(input logic va, input logic [AW-1:0] pa,
                        input logic cr, input logic [AW-1:0] ca);
        video_active = va;
        pix_addr     = pa;
        col_req      = cr;
        col_addr     = ca;
        model_edge(va, pa, cr, ca);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0)
            return bg_addr($urandom_range(0, BG_WIDTH - 1), $urandom_range(0, BG_HEIGHT - 1));
        return AW'($urandom_range(0, 32'h7FFFF));
    endfunction

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand_addr(), 1'b0, '0);
    endtask

    // Hold a collision request until the DUT grants it; n = edges taken
    task automatic hold_req(input logic va, input logic [AW-1:0] ca, input int limit, output int n);
        n = 0;
        do begin
            step(va, pix_ptr, 1'b1, ca);
            pix_ptr = pix_ptr + 1'b1;
            n++;
        end while (!col_gnt && n < limit);
        check("gnt_seen", 32'(col_gnt), 32'd1);
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst = 1'b1;
        #1;
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_pix_data",  32'(pix_data),  32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_col_gnt",   32'(col_gnt),   32'd0);
        check("rst_col_data",  32'(col_data),  32'd0);
        check("rst_col_valid", 32'(col_valid), 32'd0);
        addr_q.delete();
        gnt_q.delete();
        pix_q.delete();
        col_q.delete();
        grant_ok_at  = 0;
        wait_cycles  = 0;
        last_pix     = '0;
        video_active = 1'b0;
        col_req      = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every cycle the DUT outputs are compared against whatever the model scheduled for that edge
    logic [DW-1:0] mon_last_pix;
    logic [DW-1:0] mon_last_col;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_g;
        if (rst) begin
            mon_last_pix = '0;
            mon_last_col = '0;
        end else begin
            if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
                e = addr_q.pop_front();
                check("bram_addr", 32'(bram_addr), e.val);
            end
            exp_g = (gnt_q.size() > 0 && gnt_q[0].due == cyc);
            if (exp_g) void'(gnt_q.pop_front());
            check("col_gnt", 32'(col_gnt), 32'(exp_g));
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                e = pix_q.pop_front();
                check("pix_valid", 32'(pix_valid), 32'd1);
                check("pix_data", 32'(pix_data), e.val);
                mon_last_pix = e.val[DW-1:0];
            end else begin
                check("pix_valid_low", 32'(pix_valid), 32'd0);
                check("pix_data_hold", 32'(pix_data), 32'(mon_last_pix));
            end
            if (col_q.size() > 0 && col_q[0].due == cyc) begin
                e = col_q.pop_front();
                check("col_valid", 32'(col_valid), 32'd1);
                check("col_data", 32'(col_data), e.val);
                mon_last_col = e.val[DW-1:0];
            end else begin
                check("col_valid_low", 32'(col_valid), 32'd0);
                check("col_data_hold", 32'(col_data), 32'(mon_last_col));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic          va, cr;
        logic [AW-1:0] ca;

        rst          = 1'b0;
        video_active = 1'b0;
        pix_addr     = '0;
        col_req      = 1'b0;
        col_addr     = '0;
        pix_ptr      = '0;
        do_reset(3);

        // idle after reset: bram_addr follows pix_addr, nothing valid
        idle_steps(5);

        // one full active line
        for (int x = 0; x < BG_WIDTH; x++) step(1'b1, bg_addr(x, 0), 1'b0, '0);
        idle_steps(2);

        // blanking lookup
        hold_req(1'b0, 19'd1283, 8, n);
        check("blank_gnt_wait", 32'(n), 32'd1);
        idle_steps(4);

`ifndef ARB_STARVE_GUARD_EN
        // request during active video waits for blanking
        for (int i = 0; i < 100; i++) begin
            step(1'b1, pix_ptr, 1'b1, 19'd4242);
            pix_ptr = pix_ptr + 1'b1;
        end
        hold_req(1'b0, 19'd4242, 8, n);
        check("contention_gnt_wait", 32'(n), 32'd1);
        idle_steps(4);
`endif

        // back-to-back requests with a new address after each grant
        for (int k = 0; k < 6; k++) begin
            hold_req(1'b0, rand_addr(), 10, n);
            if (k > 0) check("b2b_spacing", 32'(n), 32'(RD_LAT + 3));
        end
        idle_steps(4);

        // reset while a collision read is in flight drops it
        hold_req(1'b0, 19'd555, 8, n);
        do_reset(2);
        idle_steps(3);
        hold_req(1'b0, 19'd777, 8, n);
        check("post_rst_gnt_wait", 32'(n), 32'd1);
        idle_steps(4);

`ifdef ARB_STARVE_GUARD_EN
        // starvation guard steals one pixel slot
        hold_req(1'b1, 19'd999, 40, n);
        check("guard_gnt_wait", 32'(n), 32'(STARVE_LIMIT + 1));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pix_ptr, 1'b0, '0);
            pix_ptr = pix_ptr + 1'b1;
        end
        idle_steps(4);
`endif

        // randomized mix with legal cancels and re-requests
        va = 1'b0;
        cr = 1'b0;
        ca = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) va = ~va;
            if (cr && col_gnt) begin
                cr = 1'($urandom_range(0, 1));
                ca = rand_addr();
            end else if (!cr) begin
                if ($urandom_range(0, 5) == 0) begin
                    cr = 1'b1;
                    ca = rand_addr();
                end
            end else if ($urandom_range(0, 40) == 0) begin
                cr = 1'b0;
            end
            step(va, rand_addr(), cr, ca);
        end
        idle_steps(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
